// File: rtl/axi_udp_tx_sched.sv
// Frame-level TX scheduler: ARP strict priority (burst-limited) over round-robin UDP, grant held to tlast, then IFG.
// One-cycle arbitration in IDLE, zero-latency combinational passthrough in XFER; m_tready feeds only the granted source's s_tready.
module axi_udp_tx_sched #(
    parameter int DATA_W        = 8,
    parameter int NUM_SRC       = 3,
    parameter int IFG_CYCLES    = 12,
    parameter int ARP_BURST_MAX = 4
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_SRC*DATA_W-1:0]     s_tdata,
    input  logic [NUM_SRC*DATA_W/8-1:0]   s_tkeep,
    input  logic [NUM_SRC-1:0]            s_tlast,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    output logic [NUM_SRC-1:0]            s_tready,
    output logic [DATA_W-1:0]             m_tdata,
    output logic [DATA_W/8-1:0]           m_tkeep,
    output logic                          m_tlast,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id,
    output logic                          busy,
    output logic [31:0]                   frame_cnt
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int KW = DATA_W / 8;
    localparam int RW = $clog2(ARP_BURST_MAX + 1);
    localparam int CW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [CW-1:0] GAP_LOAD = (IFG_CYCLES > 0) ? CW'(IFG_CYCLES - 1) : '0;
    localparam logic [RW-1:0] ARP_MAX  = RW'(ARP_BURST_MAX);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   rr_ptr, udp_win, rr_nxt;
    logic [GW:0]     cand;
    logic [RW-1:0]   arp_run;
    logic [CW-1:0]   gap_cnt;
    logic            udp_wait, udp_found, arp_win, eof;

    assign udp_wait = |s_tvalid[NUM_SRC-1:1];
    assign arp_win  = s_tvalid[0] && !(udp_wait && arp_run == ARP_MAX);
    assign eof      = busy && s_tvalid[grant_id] && m_tready && s_tlast[grant_id];
    assign rr_nxt   = (udp_win == GW'(NUM_SRC - 1)) ? GW'(1) : udp_win + GW'(1);

    // Round-robin search over UDP ports only: start at rr_ptr, wrap NUM_SRC-1 back to 1.
    always_comb begin
        udp_found = 1'b0;
        udp_win   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_SRC - 1; k++) begin
            cand = {1'b0, rr_ptr} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_SRC))
                cand = cand - (GW+1)'(NUM_SRC - 1);
            if (!udp_found && s_tvalid[cand[GW-1:0]]) begin
                udp_found = 1'b1;
                udp_win   = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        m_tdata   = s_tdata[int'(grant_id)*DATA_W +: DATA_W];
        m_tkeep   = s_tkeep[int'(grant_id)*KW +: KW];
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        s_tready  = '0;
        case (state)
            IDLE: if (|s_tvalid) state_nxt = XFER;
            XFER: begin
                busy     = 1'b1;
                m_tvalid = s_tvalid[grant_id];
                m_tlast  = s_tlast[grant_id];
                s_tready = NUM_SRC'(m_tready) << grant_id;
                if (eof) state_nxt = (IFG_CYCLES > 0) ? GAP : IDLE;
            end
            GAP:  if (gap_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            grant_id  <= '0;
            rr_ptr    <= GW'(1);
            arp_run   <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |s_tvalid) begin
                if (arp_win) begin
                    grant_id <= '0;
                    // Streak only counts while UDP traffic is actually being held off.
                    if (!udp_wait)
                        arp_run <= '0;
                    else if (arp_run != ARP_MAX)
                        arp_run <= arp_run + RW'(1);
                end else begin
                    grant_id <= udp_win;
                    rr_ptr   <= rr_nxt;
                    arp_run  <= '0;
                end
            end
            if (eof) begin
                frame_cnt <= frame_cnt + 32'd1;
                gap_cnt   <= GAP_LOAD;
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_axi_udp_tx_sched.sv
// Bench for axi_udp_tx_sched: per-source beat queues drive the ports, a timeline/transaction model predicts every output.
module tb_axi_udp_tx_sched;
    localparam int N = 3, DW = 8, KW = 1, IFG = 12, AMAX = 4, GW = 2, DEPTH = 1024;

    logic                aclk = 1'b0;
    logic                areset;
    logic [N*DW-1:0]     s_tdata;
    logic [N*KW-1:0]     s_tkeep;
    logic [N-1:0]        s_tlast, s_tvalid, s_tready;
    logic [DW-1:0]       m_tdata;
    logic [KW-1:0]       m_tkeep;
    logic                m_tlast, m_tvalid, m_tready;
    logic [GW-1:0]       grant_id;
    logic                busy;
    logic [31:0]         frame_cnt;

    always #5 aclk = ~aclk;

    axi_udp_tx_sched #(.DATA_W(DW), .NUM_SRC(N), .IFG_CYCLES(IFG), .ARP_BURST_MAX(AMAX)) dut (
        .aclk(aclk), .areset(areset),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .grant_id(grant_id), .busy(busy), .frame_cnt(frame_cnt)
    );

    int vectors = 0, miscompares = 0;

    // Source side: beats {last, data} queued per port, pres = beat currently offered
    logic [DW:0]  mem [N][DEPTH];
    int           head [N];
    int           tail [N];
    logic [N-1:0] pres;
    bit           stall_en;
    int           ready_mode;

    // Reference model: which frame is on the wire and when arbitration may next happen
    bit           in_frame;
    int           cur, free_at, cyc, streak, rr;
    logic [31:0]  fcnt;
    int           glog[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int src, input int len);
        for (int b = 0; b < len; b++) begin
            mem[src][tail[src] % DEPTH] = {(b == len - 1), DW'($urandom)};
            tail[src]++;
        end
    endtask

    task automatic model_reset();
        in_frame = 0; streak = 0; rr = 1; fcnt = '0; free_at = cyc; pres = '0;
        for (int i = 0; i < N; i++) head[i] = tail[i];
    endtask

    // ARP wins unless it has already taken AMAX frames in a row while UDP waits;
    // otherwise the next UDP port in circular order 1..N-1 starting from rr.
    task automatic arbitrate(input logic [N-1:0] v, output int w);
        bit udp_any;
        udp_any = |v[N-1:1];
        w = -1;
        if (v[0] && !(udp_any && streak >= AMAX)) begin
            w = 0;
            streak = udp_any ? streak + 1 : 0;
        end else begin
            for (int k = 0; k < N - 1; k++) begin
                int s;
                s = 1 + (rr - 1 + k) % (N - 1);
                if (w < 0 && v[s]) begin
                    w = s;
                    streak = 0;
                    rr = 1 + s % (N - 1);
                end
            end
        end
    endtask

    // Called at posedge+1: offers inputs, checks outputs, advances the model across the next edge.
    task automatic step();
        logic [N-1:0] exp_rdy;
        logic [DW:0]  beat;
        int           w;
        for (int i = 0; i < N; i++)
            if (!pres[i] && head[i] != tail[i])
                pres[i] = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        for (int i = 0; i < N; i++) begin
            beat = pres[i] ? mem[i][head[i] % DEPTH] : '0;
            s_tvalid[i]          = pres[i];
            s_tdata[i*DW +: DW]  = beat[DW-1:0];
            s_tlast[i]           = beat[DW];
        end
        s_tkeep  = '1;
        m_tready = (ready_mode == 0) ? 1'b1 :
                   (ready_mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
        #1;
        exp_rdy = '0;
        if (in_frame && m_tready) exp_rdy[cur] = 1'b1;
        check("busy", 32'(busy), 32'(in_frame));
        check("frame_cnt", frame_cnt, fcnt);
        check("s_tready", 32'(s_tready), 32'(exp_rdy));
        check("m_tvalid", 32'(m_tvalid), 32'(in_frame && pres[cur]));
        if (in_frame) begin
            check("grant_id", 32'(grant_id), cur);
            if (pres[cur]) begin
                beat = mem[cur][head[cur] % DEPTH];
                check("m_tdata", 32'(m_tdata), 32'(beat[DW-1:0]));
                check("m_tkeep", 32'(m_tkeep), 32'(1));
                check("m_tlast", 32'(m_tlast), 32'(beat[DW]));
            end
        end
        if (in_frame) begin
            if (pres[cur] && m_tready) begin
                beat = mem[cur][head[cur] % DEPTH];
                head[cur]++;
                pres[cur] = 1'b0;
                if (beat[DW]) begin
                    fcnt++;
                    in_frame = 0;
                    free_at = cyc + 1 + IFG;
                end
            end
        end else if (cyc >= free_at && |pres) begin
            arbitrate(pres, w);
            cur = w;
            in_frame = 1;
            glog.push_back(w);
        end
        cyc++;
        @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        int budget;
        bit pending;
        budget = 0;
        pending = 1;
        while (pending && budget < 3000) begin
            pending = in_frame || cyc < free_at;
            for (int i = 0; i < N; i++) if (head[i] != tail[i]) pending = 1;
            if (pending) begin
                step();
                budget++;
            end
        end
        check("drain_timeout", 32'(budget < 3000), 32'(1));
    endtask

    initial begin
        int exp3 [7];
        int b;
        exp3 = '{0, 0, 0, 0, 2, 0, 0};
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
        cyc = 0; stall_en = 0; ready_mode = 0;
        s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tvalid = '0; m_tready = 1'b0;
        areset = 1'b1;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_grant", 32'(grant_id), 32'(0));
        check("rst_mvalid", 32'(m_tvalid), 32'(0));
        check("rst_sready", 32'(s_tready), 32'(0));
        check("rst_frame_cnt", frame_cnt, 32'(0));
        @(posedge aclk);
        #1;
        areset = 1'b0;

        // Single UDP source, back-to-back frames: arbitration latency and exact IFG
        push_frame(1, 5);
        push_frame(1, 5);
        drain();

        // ARP vs UDP with burst guard
        glog.delete();
        for (int f = 0; f < 6; f++) push_frame(0, 2);
        push_frame(2, 2);
        drain();
        check("arp_grant_cnt", glog.size(), 7);
        for (int i = 0; i < 7 && i < glog.size(); i++) check("arp_grant_seq", glog[i], exp3[i]);

        // UDP round-robin alternation
        glog.delete();
        for (int f = 0; f < 3; f++) begin push_frame(1, 3); push_frame(2, 3); end
        drain();
        check("rr_grant_cnt", glog.size(), 6);
        for (int i = 0; i < 6 && i < glog.size(); i++) check("rr_grant_seq", glog[i], (i % 2 == 0) ? 1 : 2);

        // Backpressure: toggling m_tready on an 8-beat frame, other source held off
        ready_mode = 1;
        push_frame(1, 8);
        push_frame(2, 4);
        drain();

        // frame_cnt wrap
        ready_mode = 0;
        force dut.frame_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.frame_cnt;
        fcnt = 32'hFFFF_FFFF;
        push_frame(2, 3);
        drain();
        check("frame_cnt_wrap", frame_cnt, 32'(0));

        // Randomized traffic with source stalls and random backpressure
        stall_en = 1;
        ready_mode = 2;
        for (int it = 0; it < 40; it++) begin
            push_frame($urandom_range(0, N - 1), $urandom_range(1, 6));
            if ($urandom_range(0, 1) == 1) push_frame($urandom_range(0, N - 1), $urandom_range(1, 6));
            repeat ($urandom_range(5, 25)) step();
        end
        drain();

        // Reset asserted mid-frame
        stall_en = 0;
        ready_mode = 0;
        push_frame(1, 20);
        b = 0;
        while (!in_frame && b < 100) begin step(); b++; end
        check("xfer_reached", 32'(in_frame), 32'(1));
        repeat (3) step();
        #2;
        areset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_mvalid", 32'(m_tvalid), 32'(0));
        check("midrst_sready", 32'(s_tready), 32'(0));
        check("midrst_frame_cnt", frame_cnt, 32'(0));
        model_reset();
        s_tvalid = '0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (3) step();
        push_frame(2, 2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
